// File: rtl/pe_v7_pkg.sv
// pe_v7_pkg: shared types and the saturating accumulate helper for the v7 vector PE
package pe_v7_pkg;
  localparam int MAX_W = 64;
  typedef enum logic {MODE_CHAIN, MODE_ACCUM} mode_e;
  typedef logic signed [15:0] operand_t;
  typedef logic signed [MAX_W-1:0] acc_t;
  typedef acc_t [5:0] acc_vec_t;
  function automatic acc_t sat_add(input acc_t acc, input acc_t prod, input int acc_w, input bit sat);
    logic signed [MAX_W:0] s, hi, lo;
    s = {acc[MAX_W-1], acc} + {prod[MAX_W-1], prod};
    hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (acc_w - 1));
    sat_add = !sat ? s[MAX_W-1:0] : s > hi ? hi[MAX_W-1:0] : s < lo ? lo[MAX_W-1:0] : s[MAX_W-1:0];
  endfunction
endpackage

// File: rtl/pe_v7_lane.sv
// pe_v7_lane: one lane of product register, chain/accumulate adder and optional saturation
module pe_v7_lane import pe_v7_pkg::*; #(
  parameter int REG_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int SATURATE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld,
  input  logic signed [REG_WIDTH-1:0] a,
  input  logic signed [REG_WIDTH-1:0] b,
  input  logic        [ACC_WIDTH-1:0] c,
  input  logic                        s2_valid,
  input  logic                        s2_accum,
  input  logic                        s2_first,
  input  logic                        s2_emit,
  output logic        [ACC_WIDTH-1:0] c_out
);
  logic signed [2*REG_WIDTH-1:0] p;
  logic signed [ACC_WIDTH-1:0] c_r, acc, addend, sum;
  always_comb begin
    addend = !s2_accum ? c_r : s2_first ? '0 : acc;
    sum = ACC_WIDTH'(sat_add(acc_t'(addend), acc_t'(p), ACC_WIDTH, SATURATE != 0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      c_r <= '0;
      acc <= '0;
      c_out <= '0;
    end else begin
      if (ld) begin
        p <= (2*REG_WIDTH)'(a) * (2*REG_WIDTH)'(b);
        c_r <= c;
      end
      if (s2_valid && s2_accum) acc <= sum;
      if (s2_valid && s2_emit) c_out <= sum;
    end
  end
endmodule

// File: rtl/pe_vec_mac_v7.sv
// pe_vec_mac_v7: vector MAC processing element with chain and output-stationary accumulate modes
module pe_vec_mac_v7 import pe_v7_pkg::*; #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR = 6,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 8,
  parameter int SATURATE = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              mode,
  input  logic [CNT_WIDTH-1:0]              k_len,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]  a_in,
  input  logic [REG_WIDTH-1:0]              b_in,
  input  logic [VECTOR-1:0][ACC_WIDTH-1:0]  c_in,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]  a_out,
  output logic [REG_WIDTH-1:0]              b_out,
  output logic                              fwd_valid,
  output logic [VECTOR-1:0][ACC_WIDTH-1:0]  c_out,
  output logic                              c_valid,
  output logic                              busy
);
  logic [CNT_WIDTH-1:0] cnt, len_r, len_eff;
  mode_e mode_r, mode_eff;
  logic first, last, v1, acc1, first1, emit1;
  always_comb begin
    first = cnt == '0;
    mode_eff = first ? mode_e'(mode) : mode_r;
    len_eff = !first ? len_r : k_len == '0 ? CNT_WIDTH'(1) : k_len;
    last = cnt + CNT_WIDTH'(1) == len_eff;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      len_r <= '0;
      mode_r <= MODE_CHAIN;
      v1 <= 1'b0;
      acc1 <= 1'b0;
      first1 <= 1'b0;
      emit1 <= 1'b0;
      c_valid <= 1'b0;
      busy <= 1'b0;
      fwd_valid <= 1'b0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      fwd_valid <= in_valid;
      v1 <= in_valid;
      c_valid <= v1 && emit1;
      if (in_valid) begin
        a_out <= a_in;
        b_out <= b_in;
        acc1 <= mode_eff == MODE_ACCUM;
        first1 <= first;
        emit1 <= mode_eff == MODE_CHAIN || last;
        if (first) begin
          mode_r <= mode_eff;
          len_r <= len_eff;
        end
        if (mode_eff == MODE_ACCUM) begin
          cnt <= last ? '0 : cnt + CNT_WIDTH'(1);
          busy <= !last;
        end
      end
    end
  end
  for (genvar i = 0; i < VECTOR; i++) begin : g_lane
    pe_v7_lane #(.REG_WIDTH(REG_WIDTH), .ACC_WIDTH(ACC_WIDTH), .SATURATE(SATURATE)) u_lane (
      .clk(clk),
      .rst(rst),
      .ld(in_valid),
      .a(a_in[i]),
      .b(b_in),
      .c(c_in[i]),
      .s2_valid(v1),
      .s2_accum(acc1),
      .s2_first(first1),
      .s2_emit(emit1),
      .c_out(c_out[i])
    );
  end
endmodule

// File: tb/tb_pe_vec_mac_v7.sv
// tb_pe_vec_mac_v7: scoreboard bench for chain, accumulate, reset-abort and saturation behaviour
module tb_pe_vec_mac_v7;
  typedef struct { logic [5:0][39:0] d; int t; } exp40_t;
  typedef struct { logic [5:0][31:0] d; int t; } exp32_t;
  logic clk = 0, rst = 1, in_valid = 0, mode = 0, v32 = 0;
  logic [7:0] k_len = 0;
  logic [5:0][15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [5:0][39:0] c_in = '0;
  logic [5:0][31:0] c32 = '0;
  logic [5:0][15:0] a_out, a_out_s, a_out_w;
  logic [15:0] b_out, b_out_s, b_out_w;
  logic fwd_valid, fwd_valid_s, fwd_valid_w, c_valid, c_valid_s, c_valid_w, busy, busy_s, busy_w;
  logic [5:0][39:0] c_out;
  logic [5:0][31:0] c_out_s, c_out_w;
  int cyc = 0, n_tests = 0, n_fail = 0, n_pulse = 0;
  exp40_t q[$];
  exp32_t qs[$], qw[$];
  exp40_t em;
  exp32_t es, ew;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pe_vec_mac_v7 dut (.clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .k_len(k_len),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .a_out(a_out), .b_out(b_out), .fwd_valid(fwd_valid),
    .c_out(c_out), .c_valid(c_valid), .busy(busy));
  pe_vec_mac_v7 #(.ACC_WIDTH(32), .SATURATE(1)) dut_s (.clk(clk), .rst(rst), .in_valid(v32), .mode(1'b0),
    .k_len(k_len), .a_in(a_in), .b_in(b_in), .c_in(c32), .a_out(a_out_s), .b_out(b_out_s),
    .fwd_valid(fwd_valid_s), .c_out(c_out_s), .c_valid(c_valid_s), .busy(busy_s));
  pe_vec_mac_v7 #(.ACC_WIDTH(32), .SATURATE(0)) dut_w (.clk(clk), .rst(rst), .in_valid(v32), .mode(1'b0),
    .k_len(k_len), .a_in(a_in), .b_in(b_in), .c_in(c32), .a_out(a_out_w), .b_out(b_out_w),
    .fwd_valid(fwd_valid_w), .c_out(c_out_w), .c_valid(c_valid_w), .busy(busy_w));
  function automatic logic [5:0][15:0] splat16(input int v);
    for (int i = 0; i < 6; i++) splat16[i] = 16'(v);
  endfunction
  function automatic logic [5:0][39:0] splat40(input int v);
    for (int i = 0; i < 6; i++) splat40[i] = 40'(v);
  endfunction
  function automatic logic [5:0][31:0] splat32(input logic [31:0] v);
    for (int i = 0; i < 6; i++) splat32[i] = v;
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic beat(input logic m, input logic [7:0] kl, input logic [5:0][15:0] av, input int bv, input int cv);
    @(posedge clk);
    #1;
    in_valid = 1;
    mode = m;
    k_len = kl;
    a_in = av;
    b_in = 16'(bv);
    c_in = splat40(cv);
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 0;
    v32 = 0;
  endtask
  task automatic push(input logic [5:0][39:0] d);
    q.push_back('{d: d, t: cyc + 2});
  endtask
  always @(negedge clk) if (c_valid) begin
    n_pulse++;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL main unexpected c_valid at cycle %0d c_out=%h", cyc, c_out);
    end else begin
      em = q.pop_front();
      if (c_out !== em.d || cyc != em.t) begin
        n_fail++;
        $display("FAIL main result: got %h at cycle %0d, expected %h at cycle %0d", c_out, cyc, em.d, em.t);
      end
    end
  end
  always @(negedge clk) if (c_valid_s) begin
    n_tests++;
    if (qs.size() == 0) begin
      n_fail++;
      $display("FAIL sat unexpected c_valid at cycle %0d", cyc);
    end else begin
      es = qs.pop_front();
      if (c_out_s !== es.d || cyc != es.t) begin
        n_fail++;
        $display("FAIL sat result: got %h at cycle %0d, expected %h at cycle %0d", c_out_s, cyc, es.d, es.t);
      end
    end
  end
  always @(negedge clk) if (c_valid_w) begin
    n_tests++;
    if (qw.size() == 0) begin
      n_fail++;
      $display("FAIL wrap unexpected c_valid at cycle %0d", cyc);
    end else begin
      ew = qw.pop_front();
      if (c_out_w !== ew.d || cyc != ew.t) begin
        n_fail++;
        $display("FAIL wrap result: got %h at cycle %0d, expected %h at cycle %0d", c_out_w, cyc, ew.d, ew.t);
      end
    end
  end
  initial begin
    int t1[6];
    logic [5:0][39:0] e1;
    logic [5:0][15:0] a1;
    t1 = '{13, 16, 19, -2, 25, -8};
    a1 = {16'hFFFA, 16'd5, 16'hFFFC, 16'd3, 16'd2, 16'd1};
    for (int i = 0; i < 6; i++) e1[i] = 40'(t1[i]);
    // traffic while reset is held must leave no trace
    beat(1'b0, 8'd0, splat16(7), 7, 7);
    beat(1'b1, 8'd3, splat16(5), 5, 5);
    beat(1'b0, 8'd0, splat16(9), 9, 9);
    chk("rst c_out", 256'(c_out), 256'(0));
    chk("rst c_valid", 256'(c_valid), 256'(0));
    chk("rst busy", 256'(busy), 256'(0));
    chk("rst fwd_valid", 256'(fwd_valid), 256'(0));
    chk("rst a_out", 256'(a_out), 256'(0));
    chk("rst b_out", 256'(b_out), 256'(0));
    in_valid = 0;
    rst = 0;
    idle();
    idle();
    idle();
    chk("post-rst no pulse", 256'(n_pulse), 256'(0));
    chk("post-rst c_out", 256'(c_out), 256'(0));
    beat(1'b0, 8'd0, splat16(1), 1, 0);
    push(splat40(1));
    idle();
    idle();
    // single CHAIN beat with mixed-sign lanes
    beat(1'b0, 8'd0, a1, 3, 10);
    push(e1);
    idle();
    chk("fwd_valid after beat", 256'(fwd_valid), 256'(1));
    chk("a_out forward", 256'(a_out), 256'(a1));
    chk("b_out forward", 256'(b_out), 256'(3));
    idle();
    chk("fwd_valid drop", 256'(fwd_valid), 256'(0));
    chk("a_out hold", 256'(a_out), 256'(a1));
    idle();
    chk("busy idle", 256'(busy), 256'(0));
    // ACCUM k=4 with a bubble and a mid-run mode toggle
    beat(1'b1, 8'd4, splat16(2), 1, 0);
    beat(1'b1, 8'd4, splat16(2), 2, 0);
    chk("busy beat1+1", 256'(busy), 256'(1));
    idle();
    chk("busy beat2+1", 256'(busy), 256'(1));
    beat(1'b0, 8'd9, splat16(2), 3, 100);
    chk("busy bubble", 256'(busy), 256'(1));
    beat(1'b1, 8'd4, splat16(2), 4, 0);
    chk("busy beat3+1", 256'(busy), 256'(1));
    push(splat40(20));
    idle();
    chk("busy after last", 256'(busy), 256'(0));
    idle();
    idle();
    // back-to-back k=2 runs
    beat(1'b1, 8'd2, splat16(1), 5, 0);
    beat(1'b1, 8'd2, splat16(1), 5, 0);
    push(splat40(10));
    beat(1'b1, 8'd2, splat16(1), 1, 0);
    beat(1'b1, 8'd2, splat16(1), 1, 0);
    push(splat40(2));
    idle();
    // k_len = 0 behaves as a single-beat run
    beat(1'b1, 8'd0, splat16(2), 7, 0);
    push(splat40(14));
    idle();
    idle();
    idle();
    // reset aborts a k=4 run after two beats
    beat(1'b1, 8'd4, splat16(1), 1, 0);
    beat(1'b1, 8'd4, splat16(1), 1, 0);
    @(posedge clk);
    #1;
    in_valid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    idle();
    idle();
    idle();
    chk("abort no pulse", 256'(n_pulse), 256'(6));
    chk("abort busy", 256'(busy), 256'(0));
    beat(1'b1, 8'd1, splat16(3), 3, 0);
    push(splat40(9));
    idle();
    idle();
    idle();
    // saturating and wrapping 32-bit instances
    @(posedge clk);
    #1;
    in_valid = 0;
    v32 = 1;
    a_in = splat16(16);
    b_in = 16'd16;
    c32 = splat32(32'h7FFFFFF0);
    qs.push_back('{d: splat32(32'h7FFFFFFF), t: cyc + 2});
    qw.push_back('{d: splat32(32'h800000F0), t: cyc + 2});
    @(posedge clk);
    #1;
    a_in = splat16(-16);
    c32 = splat32(32'h80000010);
    qs.push_back('{d: splat32(32'h80000000), t: cyc + 2});
    qw.push_back('{d: splat32(32'h7FFFFF10), t: cyc + 2});
    idle();
    for (int i = 0; i < 5; i++) idle();
    chk("main pulse count", 256'(n_pulse), 256'(7));
    chk("main queue drained", 256'(q.size()), 256'(0));
    chk("sat queue drained", 256'(qs.size()), 256'(0));
    chk("wrap queue drained", 256'(qw.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
